// File: rtl/dcache_pkg.sv
// Shared types and address field helpers for the data-cache tag controller.
package dcache_pkg;

  localparam int unsigned LINE_OFS = 4;
  localparam int unsigned ADR_W    = 28;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    UPDATE,
    REPLAY
  } dc_state_e;

  // Line index field, right-aligned; caller casts to DRWIDTH bits.
  function automatic logic [ADR_W-1:0] idx_of(input logic [ADR_W-1:0] adr,
                                               input int unsigned drw);
    return (adr >> LINE_OFS) & ((ADR_W'(1) << drw) - ADR_W'(1));
  endfunction

  // Tag field, right-aligned; caller casts to tag width.
  function automatic logic [ADR_W-1:0] tag_of(input logic [ADR_W-1:0] adr,
                                               input int unsigned drw);
    return adr >> (LINE_OFS + drw);
  endfunction

endpackage

// File: rtl/dcache_vd_bits.sv
// Valid/dirty flop array, one bit pair per cache line, asynchronously cleared.
module dcache_vd_bits #(
  parameter int unsigned DRWIDTH = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DRWIDTH-1:0] rd_idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  input  logic               fill_en,
  input  logic [DRWIDTH-1:0] fill_idx,
  input  logic               dirty_en,
  input  logic [DRWIDTH-1:0] dirty_idx
);

  localparam int unsigned NLINES = 1 << DRWIDTH;

  logic [NLINES-1:0] valid_q;
  logic [NLINES-1:0] dirty_q;

  // Fill marks a line valid+clean; a store hit marks a line dirty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
        dirty_q[fill_idx] <= 1'b0;
      end
      if (dirty_en) begin
        dirty_q[dirty_idx] <= 1'b1;
      end
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];

endmodule

// File: rtl/dcache_tag_ctrl.sv
// Direct-mapped D-cache lookup/miss controller: tag RAM ports, compare, miss FSM.
module dcache_tag_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned DRWIDTH = 12,
  localparam int unsigned TW     = 24 - DRWIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADR_W-1:0]   cpu_adr,
  output logic               cpu_stall,
  output logic               cpu_hit,
  output logic [DRWIDTH-1:0] tag_radr,
  input  logic [TW-1:0]      tag_rdata,
  output logic [DRWIDTH-1:0] tag_wadr,
  output logic [TW-1:0]      tag_wdata,
  output logic               tag_wen,
  output logic               wb_req,
  output logic [ADR_W-1:0]   wb_adr,
  output logic               fill_req,
  output logic [ADR_W-1:0]   fill_adr,
  input  logic               mem_ack
);

  dc_state_e state_q, state_d;

  logic [ADR_W-LINE_OFS-1:0] cap_line_q;
  logic                      cap_we_q;
  logic [TW-1:0]             victim_q;

  logic [DRWIDTH-1:0] cap_idx;
  logic [TW-1:0]      cap_tag;
  logic [DRWIDTH-1:0] req_idx;
  logic               rd_valid;
  logic               rd_dirty;
  logic               hit;
  logic               cap_en;

  assign cap_idx = DRWIDTH'(idx_of({cap_line_q, {LINE_OFS{1'b0}}}, DRWIDTH));
  assign cap_tag = TW'(tag_of({cap_line_q, {LINE_OFS{1'b0}}}, DRWIDTH));
  assign req_idx = DRWIDTH'(idx_of(cpu_adr, DRWIDTH));

  assign hit    = (state_q == LOOKUP) && rd_valid && (tag_rdata == cap_tag);
  assign cap_en = cpu_req && ((state_q == IDLE) || hit);

  dcache_vd_bits #(
    .DRWIDTH (DRWIDTH)
  ) u_vd (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (cap_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .fill_en   (state_q == UPDATE),
    .fill_idx  (cap_idx),
    .dirty_en  (hit && cap_we_q),
    .dirty_idx (cap_idx)
  );

  // State register, request capture and victim tag capture on a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cap_line_q <= '0;
      cap_we_q   <= 1'b0;
      victim_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        cap_line_q <= cpu_adr[ADR_W-1:LINE_OFS];
        cap_we_q   <= cpu_we;
      end
      if ((state_q == LOOKUP) && !hit) begin
        victim_q <= tag_rdata;
      end
    end
  end

  // Next-state and control outputs. REPLAY re-reads the tag and returns to
  // LOOKUP, so the guaranteed hit reuses the normal compare path.
  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b0;
    cpu_hit   = 1'b0;
    tag_wen   = 1'b0;
    wb_req    = 1'b0;
    fill_req  = 1'b0;
    tag_radr  = req_idx;
    case (state_q)
      IDLE: begin
        if (cpu_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          cpu_hit = 1'b1;
          state_d = cpu_req ? LOOKUP : IDLE;
        end else begin
          cpu_stall = 1'b1;
          state_d   = (rd_valid && rd_dirty) ? WB : FILL;
        end
      end
      WB: begin
        cpu_stall = 1'b1;
        wb_req    = 1'b1;
        tag_radr  = cap_idx;
        if (mem_ack) state_d = FILL;
      end
      FILL: begin
        cpu_stall = 1'b1;
        fill_req  = 1'b1;
        tag_radr  = cap_idx;
        if (mem_ack) state_d = UPDATE;
      end
      UPDATE: begin
        cpu_stall = 1'b1;
        tag_wen   = 1'b1;
        tag_radr  = cap_idx;
        state_d   = REPLAY;
      end
      REPLAY: begin
        cpu_stall = 1'b1;
        tag_radr  = cap_idx;
        state_d   = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tag_wadr  = cap_idx;
  assign tag_wdata = cap_tag;
  assign wb_adr    = {victim_q, cap_idx, {LINE_OFS{1'b0}}};
  assign fill_adr  = {cap_line_q, {LINE_OFS{1'b0}}};

endmodule
